// File: rtl/per_outport_pkg.sv
// Register map and bit positions shared by the output-port peripheral.
package per_outport_pkg;

  // Word offsets from BASE_ADDR
  localparam int unsigned REG_DATA   = 0;
  localparam int unsigned REG_STATUS = 1;
  localparam int unsigned REG_CTRL   = 2;

  // STATUS bit positions ([8:0] hold the zero-extended count)
  localparam int unsigned ST_FULL  = 9;
  localparam int unsigned ST_EMPTY = 10;
  localparam int unsigned ST_EOF   = 11;
  localparam int unsigned ST_OVF   = 12;
  localparam int unsigned ST_ERR   = 13;

  // CTRL bit positions
  localparam int unsigned CTRL_CLEAR   = 0;
  localparam int unsigned CTRL_CLR_ERR = 1;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_DATA,
    SEL_STATUS,
    SEL_CTRL
  } reg_sel_e;

endpackage

// File: rtl/outport_fifo.sv
// Show-ahead word FIFO: storage, wrapping pointers and occupancy count.
module outport_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     mclk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [15:0]              din,
  output logic [15:0]              dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Pointer and count update; power-of-two depth makes pointer wrap free
  always_ff @(posedge mclk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!reset_n || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write; a push into a full FIFO with a same-cycle pop overwrites
  // the slot whose old word is leaving on this very edge
  always_ff @(posedge mclk) begin
    // NOTE: storage has no reset; validity is tracked by count alone, which
    // lets the array map onto plain RAM.
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/per_outport.sv
// Peripheral-bus output port: DATA/STATUS/CTRL registers in front of a
// show-ahead FIFO drained by a host consumer, with EOF/OVF/ERR flags.
module per_outport
  import per_outport_pkg::*;
#(
  parameter int          DEPTH     = 16,
  parameter logic [13:0] BASE_ADDR = 14'h0080
) (
  input  logic        mclk,
  input  logic        reset_n,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  output logic [15:0] per_dout,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_eof
);

  localparam int CW = $clog2(DEPTH) + 1;

  reg_sel_e      sel;
  logic [CW-1:0] count;
  logic          full, empty;
  logic          eof_q, ovf_q, err_q;
  logic          is_write, data_word_wr, push_req, eof_wr, byte_wr;
  logic          ctrl_wr, clear_fifo, clear_err;
  logic          pop, push_ok, drop_eof, drop_full;
  logic [15:0]   status;

  // Address decode of the three registers
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and infers a latch.
    sel = SEL_NONE;
    if (per_en) begin
      if (per_addr == 14'(BASE_ADDR + REG_DATA))        sel = SEL_DATA;
      else if (per_addr == 14'(BASE_ADDR + REG_STATUS)) sel = SEL_STATUS;
      else if (per_addr == 14'(BASE_ADDR + REG_CTRL))   sel = SEL_CTRL;
    end
  end

  assign is_write     = (per_we != 2'b00);
  assign data_word_wr = (sel == SEL_DATA) && (per_we == 2'b11);
  assign push_req     = data_word_wr && (per_din != 16'h0000);
  assign eof_wr       = data_word_wr && (per_din == 16'h0000);
  assign byte_wr      = (sel == SEL_DATA) && (per_we == 2'b01 || per_we == 2'b10);
  assign ctrl_wr      = (sel == SEL_CTRL) && is_write;
  assign clear_fifo   = ctrl_wr && per_din[CTRL_CLEAR];
  assign clear_err    = ctrl_wr && per_din[CTRL_CLR_ERR];

  // A clear outranks the consumer, so the head is not reported as taken
  assign pop       = out_valid && out_ready && !clear_fifo;
  assign drop_eof  = push_req && eof_q;
  assign drop_full = push_req && !eof_q && full && !pop;
  assign push_ok   = push_req && !eof_q && (!full || pop);

  outport_fifo #(.DEPTH(DEPTH)) u_fifo (
    .mclk    (mclk),
    .reset_n (reset_n),
    .push    (push_ok),
    .pop     (pop),
    .clear   (clear_fifo),
    .din     (per_din),
    .dout    (out_data),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // Stream flags: EOF latches until clear, OVF/ERR are sticky until cleared
  always_ff @(posedge mclk) begin
    if (!reset_n || clear_fifo) begin
      eof_q <= 1'b0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (eof_wr) eof_q <= 1'b1;
      if (clear_err) begin
        ovf_q <= 1'b0;
        err_q <= 1'b0;
      end else begin
        if (drop_full)           ovf_q <= 1'b1;
        if (byte_wr || drop_eof) err_q <= 1'b1;
      end
    end
  end

  // STATUS word assembly and read mux
  always_comb begin
    status            = '0;
    status[CW-1:0]    = count;
    status[ST_FULL]   = full;
    status[ST_EMPTY]  = empty;
    status[ST_EOF]    = eof_q;
    status[ST_OVF]    = ovf_q;
    status[ST_ERR]    = err_q;
    per_dout          = ((sel == SEL_STATUS) && !is_write) ? status : 16'h0000;
  end

  // Held low while in reset so the consumer never sees a pop it cannot get
  assign out_valid = !empty && reset_n;
  assign out_eof   = eof_q && empty;

endmodule

// File: tb/tb_per_outport.sv
// Self-checking bench for per_outport: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, random traffic.
module tb_per_outport;

  localparam int          DEPTH = 16;
  localparam logic [13:0] BASE  = 14'h0080;
  localparam logic [13:0] A_DAT = BASE;
  localparam logic [13:0] A_STA = BASE + 14'd1;
  localparam logic [13:0] A_CTL = BASE + 14'd2;

  logic        mclk;
  logic        reset_n;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;
  logic [15:0] per_dout;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_eof;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  // Reference model state
  logic [15:0] mq[$];
  bit          m_eof, m_ovf, m_err;
  // Words the DUT handed to the consumer
  logic [15:0] dut_pops[$];

  per_outport #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .mclk      (mclk),
    .reset_n   (reset_n),
    .per_addr  (per_addr),
    .per_din   (per_din),
    .per_en    (per_en),
    .per_we    (per_we),
    .per_dout  (per_dout),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_eof   (out_eof)
  );

  initial begin
    mclk = 1'b0;
    forever #5 mclk = ~mclk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_status();
    logic [15:0] s;
    s        = 16'(mq.size());
    s[9]     = (mq.size() == DEPTH);
    s[10]    = (mq.size() == 0);
    s[11]    = m_eof;
    s[12]    = m_ovf;
    s[13]    = m_err;
    return s;
  endfunction

  // Reference model: applies the register rules at each rising edge
  always @(posedge mclk) begin
    int sz;
    bit pop_now, ctrl_w;
    if (!reset_n) begin
      mq.delete();
      m_eof = 0; m_ovf = 0; m_err = 0;
    end else begin
      sz      = mq.size();
      pop_now = (sz > 0) && out_ready;
      ctrl_w  = per_en && (per_we != 2'b00) && (per_addr == A_CTL);
      if (ctrl_w && per_din[0]) begin
        mq.delete();
        m_eof = 0; m_ovf = 0; m_err = 0;
      end else begin
        if (pop_now) void'(mq.pop_front());
        if (per_en && per_addr == A_DAT) begin
          if (per_we == 2'b11) begin
            if (per_din == 16'h0000)      m_eof = 1;
            else if (m_eof)               m_err = 1;
            else if (sz == DEPTH && !pop_now) m_ovf = 1;
            else                          mq.push_back(per_din);
          end else if (per_we == 2'b01 || per_we == 2'b10) begin
            m_err = 1;
          end
        end
        if (ctrl_w && per_din[1]) begin
          m_ovf = 0; m_err = 0;
        end
      end
    end
  end

  // Compare process: outputs checked against the model mid-cycle
  always @(negedge mclk) begin
    logic exp_valid;
    logic [15:0] exp_dout;
    if (chk_en) begin
      exp_valid = reset_n && (mq.size() > 0);
      check("out_valid", 32'(out_valid), 32'(exp_valid));
      if (exp_valid) check("out_data", 32'(out_data), 32'(mq[0]));
      check("out_eof", 32'(out_eof), 32'(m_eof && mq.size() == 0));
      exp_dout = (per_en && per_we == 2'b00 && per_addr == A_STA) ? model_status() : 16'h0000;
      check("per_dout", 32'(per_dout), 32'(exp_dout));
      if (out_valid && out_ready) dut_pops.push_back(out_data);
    end
  end

  task automatic idle();
    per_en = 0; per_we = 2'b00; per_din = 16'h0000; per_addr = 14'h0000;
  endtask

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic wr(input logic [13:0] a, input logic [1:0] we, input logic [15:0] d);
    per_en = 1; per_addr = a; per_we = we; per_din = d;
    tick();
    idle();
  endtask

  task automatic status_is(input string name, input logic [15:0] exp);
    per_en = 1; per_addr = A_STA; per_we = 2'b00;
    @(negedge mclk);
    check(name, 32'(per_dout), 32'(exp));
    tick();
    idle();
  endtask

  task automatic do_reset();
    reset_n = 0;
    tick();
    reset_n = 1;
  endtask

  initial begin
    int bias;
    int r;
    reset_n = 0; out_ready = 0;
    idle();
    tick();
    chk_en = 1;
    tick();
    reset_n = 1;
    @(negedge mclk);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_eof", 32'(out_eof), 32'd0);
    check("reset_dout", 32'(per_dout), 32'd0);
    tick();
    status_is("reset_status", 16'h0400);

    // Short stream then EOF with the consumer always ready
    out_ready = 1;
    dut_pops.delete();
    wr(A_DAT, 2'b11, 16'h0002);
    wr(A_DAT, 2'b11, 16'h0003);
    wr(A_DAT, 2'b11, 16'h0005);
    wr(A_DAT, 2'b11, 16'h0000);
    @(negedge mclk);
    check("stream_pops", 32'(dut_pops.size()), 32'd3);
    if (dut_pops.size() == 3)
      check("stream_words", {8'h00, dut_pops[0][7:0], dut_pops[1][7:0], dut_pops[2][7:0]}, 32'h00020305);
    check("stream_eof", 32'(out_eof), 32'd1);
    tick();
    status_is("stream_status", 16'h0C00);

    // Overflow: seventeen words into a 16-deep FIFO, then drain
    do_reset();
    out_ready = 0;
    for (int i = 1; i <= 17; i++) wr(A_DAT, 2'b11, 16'(i));
    status_is("ovf_status", 16'h1210);
    dut_pops.delete();
    out_ready = 1;
    repeat (18) tick();
    out_ready = 0;
    check("ovf_drain_n", 32'(dut_pops.size()), 32'd16);
    for (int i = 0; i < dut_pops.size() && i < 16; i++)
      check("ovf_drain_word", 32'(dut_pops[i]), 32'(i + 1));
    status_is("ovf_after_drain", 16'h1400);

    // Push into a full FIFO with a same-cycle pop
    wr(A_CTL, 2'b11, 16'h0003);
    for (int i = 1; i <= 16; i++) wr(A_DAT, 2'b11, 16'(i));
    status_is("full_status", 16'h0210);
    dut_pops.delete();
    out_ready = 1;
    wr(A_DAT, 2'b11, 16'h00AA);
    out_ready = 0;
    status_is("full_push_pop", 16'h0210);
    out_ready = 1;
    repeat (18) tick();
    out_ready = 0;
    check("full_drain_n", 32'(dut_pops.size()), 32'd17);
    if (dut_pops.size() > 0) check("full_last", 32'(dut_pops[$]), 32'h00AA);

    // Byte write error, then clear errors leaving data intact
    wr(A_DAT, 2'b11, 16'h0011);
    wr(A_DAT, 2'b11, 16'h0022);
    wr(A_DAT, 2'b01, 16'h1234);
    status_is("byte_err", 16'h2402 & 16'hFBFF);
    wr(A_CTL, 2'b11, 16'h0002);
    status_is("err_cleared", 16'h0002);
    wr(A_STA, 2'b11, 16'h5555);
    status_is("status_wr_nop", 16'h0002);

    // Clear with pending words and EOF, consumer ready on the clear edge
    wr(A_CTL, 2'b11, 16'h0001);
    for (int i = 1; i <= 5; i++) wr(A_DAT, 2'b11, 16'(i * 3));
    wr(A_DAT, 2'b11, 16'h0000);
    status_is("eof_pending", 16'h0805);
    out_ready = 1;
    wr(A_CTL, 2'b11, 16'h0001);
    @(negedge mclk);
    check("clr_valid", 32'(out_valid), 32'd0);
    check("clr_eof", 32'(out_eof), 32'd0);
    tick();
    out_ready = 0;
    status_is("clr_status", 16'h0400);

    // Reset mid-stream
    for (int i = 1; i <= 3; i++) wr(A_DAT, 2'b11, 16'(i));
    do_reset();
    @(negedge mclk);
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    tick();
    status_is("rst_mid_status", 16'h0400);
    wr(A_DAT, 2'b11, 16'h0007);
    @(negedge mclk);
    check("rst_mid_valid2", 32'(out_valid), 32'd1);
    check("rst_mid_data", 32'(out_data), 32'h0007);
    tick();

    // Randomized traffic against the model
    bias = 50;
    for (int n = 0; n < 3000; n++) begin
      if (n % 250 == 0) bias = (n / 250) % 3 == 0 ? 10 : ((n / 250) % 3 == 1 ? 50 : 90);
      reset_n   = ($urandom_range(0, 299) != 0);
      out_ready = ($urandom_range(0, 99) < bias);
      per_en    = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 19);
      if (r < 12)      per_addr = A_DAT;
      else if (r < 15) per_addr = A_STA;
      else if (r < 17) per_addr = A_CTL;
      else if (r < 18) per_addr = BASE + 14'd3;
      else             per_addr = 14'($urandom);
      r = $urandom_range(0, 9);
      per_we  = (r < 6) ? 2'b11 : (r == 6) ? 2'b01 : (r == 7) ? 2'b10 : 2'b00;
      per_din = ($urandom_range(0, 39) == 0) ? 16'h0000 : 16'($urandom);
      tick();
    end
    reset_n = 1;
    idle();
    out_ready = 1;
    repeat (20) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
